// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronizes Rx, samples mid-bit on baud ticks, valid/ack output.
// Optional parity stage and ports enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 BaudTick,
  output logic                 BaudEn,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxAck,
  output logic                 FrameErr,
  output logic                 Overrun,
`ifdef UART_RX_PARITY_EN
  input  logic                 ParityOdd,
  output logic                 ParityErr,
`endif
  output logic                 Busy
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_dly_q, rx_dly_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   brk_q, brk_d;
  logic                   baud_en_q, baud_en_d;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
`endif

  logic rx_s;
  logic fall;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_dly_q & ~rx_s;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], Rx};
    rx_dly_d  = rx_s;
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    brk_d     = brk_q;
    valid_d   = valid_q & ~RxAck;
    ferr_d    = ferr_q & ~RxAck;
    ovr_d     = ovr_q & ~RxAck;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q & ~RxAck;
`endif
    unique case (state_q)
      IDLE: begin
        // After a framing error, wait for the line to recover before arming
        if (brk_q) begin
          brk_d = ~rx_s;
        end else if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (BaudTick) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (BaudTick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (BaudTick) begin
          if ((^shift_q ^ rx_s) != ParityOdd) perr_d = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (BaudTick) begin
          state_d = IDLE;
          if (rx_s) begin
            // A same-cycle ack frees the slot for the new byte
            if (valid_q && !RxAck) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    baud_en_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      rx_dly_q  <= 1'b1;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      brk_q     <= 1'b0;
      baud_en_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rx_dly_q  <= rx_dly_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      brk_q     <= brk_d;
      baud_en_q <= baud_en_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign BaudEn   = baud_en_q;
  assign RxData   = data_q;
  assign RxValid  = valid_q;
  assign FrameErr = ferr_q;
  assign Overrun  = ovr_q;
  assign Busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign ParityErr = perr_q;
`endif

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receive framer sitting directly downstream of the UART baud tick generator.
- Synchronizes the raw Rx line and detects the start bit. It then drives the generator's enable and consumes its one-cycle tick pulses to sample the start, data, optional parity and stop bits at mid-bit.
- Presents each received byte on a valid/ack handshake to the host side, with frame-error and overrun status.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first (legal 5..9).
- SYNC_STAGES, 2, flip-flop stages in the Rx input synchronizer (legal 2..4).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  reset, synchronous, active-high.
- Rx  input  1  asynchronous serial line, idle high.
- BaudTick  input  1  one-cycle tick from the baud generator.
- BaudEn  output  1  enable to the baud generator.
- RxData  output  DATA_BITS  last accepted byte.
- RxValid  output  1  RxData holds an unread byte.
- RxAck  input  1  host consumes the byte.
- FrameErr  output  1  sticky: the stop bit sampled low.
- Overrun  output  1  sticky: a frame completed while RxValid=1.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: every output 0, state IDLE, shift register 0, all synchronizer stages loaded 1.
- Rx passes through SYNC_STAGES flops to give rx_s. A falling edge of rx_s is detected by comparing it with its 1-cycle delayed copy.
- Baud generator contract:
  - While BaudEn=0 the generator preloads to half a bit period.
  - After BaudEn rises, the first BaudTick arrives about half a bit later, i.e. mid start bit.
  - Subsequent ticks arrive every full bit period.
- BaudEn is registered. It is 1 exactly when state is in {START, DATA, PARITY, STOP}.
- Each state samples rx_s only in a cycle with BaudTick=1. BaudTick seen in IDLE is ignored.
- States and transitions:
  - IDLE: on falling edge of rx_s, go to START.
  - START: on tick, if rx_s=0 go to DATA with bit counter=0; else (false start / glitch) go to IDLE with no status change.
  - DATA: on tick, shift rx_s into the MSB of the shift register (LSB-first reception) and increment the counter. When the counter reaches DATA_BITS-1, go to PARITY if the feature is enabled, else to STOP.
  - PARITY: present only with the optional feature; see below.
  - STOP: on tick, go to IDLE.
    - If rx_s=1 and RxValid=0: RxData <= shift register, RxValid <= 1 on the next cycle.
    - If rx_s=1 and RxValid=1: the new byte is discarded, RxData is unchanged, Overrun <= 1.
    - If rx_s=0: FrameErr <= 1 and the byte is discarded. The FSM stays in IDLE until rx_s has been high for at least one cycle (break condition), so no false start is taken on a held-low line.
- Handshake:
  - RxAck=1 while RxValid=1 clears RxValid, FrameErr and Overrun on the next edge.
  - RxAck while RxValid=0 clears only the sticky flags.
  - If RxAck and a frame completion occur in the same cycle, the completion wins: RxValid stays 1, RxData is updated, and Overrun is not set.
- Latency: RxValid rises 1 Clk after the stop-bit tick, which is about 9.5 bit periods (DATA_BITS=8, no parity) after the falling start edge, plus SYNC_STAGES+1 cycles.
- Rst asserted mid-frame: immediate return to IDLE, BaudEn=0, partial byte dropped, all flags cleared.
- Counter width is clog2(DATA_BITS) bits; there is no wrap beyond DATA_BITS-1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state between DATA and STOP, and a port ParityOdd (input, 1 bit; 0=even, 1=odd) and a port ParityErr (output, 1 bit, sticky, reset 0).
  - On the parity tick, ParityErr is set if XOR(data bits, rx_s) != ParityOdd.
  - The byte is still delivered if the stop bit is good.
  - ParityErr is cleared by RxAck like the other flags.
- Undefined: no PARITY state, no parity ports; frame is start + DATA_BITS + stop.

Test Plan:
- Bench setup: baud generator instantiated with a 101-Clk bit period, with BaudEn/BaudTick wired. Sending 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> RxData=0xA5 and RxValid=1, with FrameErr=0 and Overrun=0; RxAck pulse -> RxValid=0 next cycle.
- Rx low pulse of 30 Clk (shorter than half a bit) -> START sees rx_s=1 at the first tick, return to IDLE, BaudEn drops, RxValid stays 0.
- 0x3C sent with the stop bit held low, then the line held low 500 Clk -> FrameErr=1, RxValid=0, Busy=0, and no new frame while the line is low. The line going high, then 0x3C sent -> RxValid=1, RxData=0x3C.
- Two frames 0x11 then 0x22 without RxAck -> RxData=0x11 and Overrun=1. A subsequent RxAck clears RxValid and Overrun.
- Rst asserted mid-frame at bit 4 of 0xFF -> BaudEn=0, Busy=0, RxValid=0 next cycle. The next frame 0x0F is received correctly.
- With UART_RX_PARITY_EN and ParityOdd=0: 0x07 with parity bit 1 -> ParityErr=0; 0x07 with parity bit 0 -> ParityErr=1, with RxValid=1 and RxData=0x07 in both cases.
